// File: rtl/sc_rx_decrypt.sv
// rtl/sc_rx_decrypt.sv - receive-side keystream decryptor (Galois LFSR, valid/ready, key prime)
// Optional SC_RX_BYTECNT_EN adds a byte_cnt output counting transfers since the last key_load.
module sc_rx_decrypt #(
  parameter int          WARMUP = 4,
  parameter logic [15:0] TAPS   = 16'hB400
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        key_load,
  input  logic [15:0] key,
  output logic        busy,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready
`ifdef SC_RX_BYTECNT_EN
  ,
  output logic [15:0] byte_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  localparam logic [15:0] WARM_INIT = 16'(WARMUP);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_lfsr;
  logic [15:0] r_warm;
  logic [15:0] w_lfsr_adv;
  logic [7:0]  w_ks;
  logic        w_xfer;
`ifdef SC_RX_BYTECNT_EN
  logic [15:0] r_byte_cnt;
  assign byte_cnt = r_byte_cnt;
`endif

  // Eight Galois steps unrolled; keystream bit i is the lsb shifted out at step i.
  always_comb begin : keystream
    logic [15:0] s;
    s    = r_lfsr;
    w_ks = '0;
    for (int i = 0; i < 8; i++) begin
      w_ks[i] = s[0];
      s       = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    end
    w_lfsr_adv = s;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    in_ready    = 1'b0;
    case (r_state)
      PRIME: begin
        busy = 1'b1;
        if (r_warm <= 16'd1) w_state_nxt = RUN;
      end
      RUN:     in_ready = !key_load && (!out_valid || out_ready);
      default: ;
    endcase
    if (key_load) w_state_nxt = (WARMUP == 0) ? RUN : PRIME;
  end

  assign w_xfer = in_valid && in_ready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_lfsr     <= '0;
      r_warm     <= '0;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
`ifdef SC_RX_BYTECNT_EN
      r_byte_cnt <= '0;
`endif
    end else if (key_load) begin
      // An all-zero seed would lock the LFSR, so it is replaced by 1.
      r_lfsr     <= (key == 16'h0000) ? 16'h0001 : key;
      r_warm     <= WARM_INIT;
      out_valid  <= 1'b0;
`ifdef SC_RX_BYTECNT_EN
      r_byte_cnt <= '0;
`endif
    end else if (r_state == PRIME) begin
      r_lfsr <= w_lfsr_adv;
      r_warm <= r_warm - 16'd1;
    end else if (w_xfer) begin
      out_data   <= in_data ^ w_ks;
      out_valid  <= 1'b1;
      r_lfsr     <= w_lfsr_adv;
`ifdef SC_RX_BYTECNT_EN
      r_byte_cnt <= r_byte_cnt + 16'd1;
`endif
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sc_rx_decrypt.sv
// tb/tb_sc_rx_decrypt.sv - randomized self-checking bench for sc_rx_decrypt
// Drives a WARMUP=4 instance and a WARMUP=0 instance against a bit-serial keystream model.
module tb_sc_rx_decrypt;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  int          total = 0;
  int          bad = 0;

  logic        k4_load = 0, k0_load = 0;
  logic [15:0] k4_key = 0, k0_key = 0;
  logic        v4 = 0, v0 = 0, r4 = 0, r0 = 0;
  logic [7:0]  d4 = 0, d0 = 0;
  logic        busy4, busy0, ir4, ir0, ov4, ov0;
  logic [7:0]  od4, od0;
`ifdef SC_RX_BYTECNT_EN
  logic [15:0] bc4, bc0;
`endif

  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  sc_rx_decrypt #(.WARMUP(4)) u_dut4 (
    .clk(clk), .nrst(nrst), .key_load(k4_load), .key(k4_key), .busy(busy4),
    .in_valid(v4), .in_data(d4), .in_ready(ir4), .out_valid(ov4), .out_data(od4),
    .out_ready(r4)
`ifdef SC_RX_BYTECNT_EN
    , .byte_cnt(bc4)
`endif
  );

  sc_rx_decrypt #(.WARMUP(0)) u_dut0 (
    .clk(clk), .nrst(nrst), .key_load(k0_load), .key(k0_key), .busy(busy0),
    .in_valid(v0), .in_data(d0), .in_ready(ir0), .out_valid(ov0), .out_data(od0),
    .out_ready(r0)
`ifdef SC_RX_BYTECNT_EN
    , .byte_cnt(bc0)
`endif
  );

  // Keystream byte from the reference sequence: eight shifted-out bits, first one in bit 0.
  function automatic logic [7:0] m_next_byte();
    logic [7:0] b;
    logic       lsb;
    for (int i = 0; i < 8; i++) begin
      lsb    = m_lfsr[0];
      m_lfsr = m_lfsr >> 1;
      if (lsb) m_lfsr = m_lfsr ^ 16'hB400;
      b[i] = lsb;
    end
    return b;
  endfunction

  task automatic load4(input logic [15:0] k);
    @(negedge clk); k4_load = 1; k4_key = k;
    @(negedge clk); k4_load = 0;
  endtask

  task automatic load0(input logic [15:0] k);
    @(negedge clk); k0_load = 1; k0_key = k;
    @(negedge clk); k0_load = 0;
  endtask

  task automatic test_reset();
    #1;
    total++; if ({ov0, ir0, busy0, od0} !== 11'h000) begin bad++; $display("FAIL reset_hold got=%h exp=000", {ov0, ir0, busy0, od0}); end
    @(negedge clk); nrst = 1;
    load0(16'h0001);
    k4_load = 1; k4_key = 16'h5555;
    v0 = 1; d0 = 8'h3C; r0 = 0;
    @(negedge clk); k4_load = 0; v0 = 0;
    #1;
    total++; if (ov0 !== 1'b1 || busy4 !== 1'b1) begin bad++; $display("FAIL reset_pre ov0=%b busy4=%b exp=1,1", ov0, busy4); end
    @(posedge clk); #3 nrst = 0; #1;
    total++; if ({ov0, ir0, busy0, od0} !== 11'h000) begin bad++; $display("FAIL reset_async got=%h exp=000", {ov0, ir0, busy0, od0}); end
    total++; if ({ov4, ir4, busy4, od4} !== 11'h000) begin bad++; $display("FAIL reset_async4 got=%h exp=000", {ov4, ir4, busy4, od4}); end
    @(negedge clk); nrst = 1; r0 = 1; v0 = 1; r4 = 1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (ir0 !== 1'b0 || ir4 !== 1'b0 || ov0 !== 1'b0) begin bad++; $display("FAIL reset_idle ir0=%b ir4=%b ov0=%b exp=0", ir0, ir4, ov0); end
    v0 = 0;
  endtask

  task automatic test_prime();
    int n;
    r4 = 1;
    @(negedge clk); k4_load = 1; k4_key = 16'hACE1;
    #1;
    total++; if (ir4 !== 1'b0) begin bad++; $display("FAIL prime_load_ready got=%b exp=0", ir4); end
    @(negedge clk); k4_load = 0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (busy4 !== 1'b1) break;
      total++; if (ir4 !== 1'b0) begin bad++; $display("FAIL prime_ready got=%b exp=0", ir4); end
      n++;
      @(negedge clk);
    end
    total++; if (n != 4) begin bad++; $display("FAIL prime_cycles got=%0d exp=4", n); end
    total++; if (ir4 !== 1'b1) begin bad++; $display("FAIL prime_run_ready got=%b exp=1", ir4); end
  endtask

  task automatic test_vectors();
    load0(16'h0001);
    #1;
    total++; if (ir0 !== 1'b1 || busy0 !== 1'b0) begin bad++; $display("FAIL vec_ready ir=%b busy=%b exp=1,0", ir0, busy0); end
    v0 = 1; d0 = 8'hA5; r0 = 1;
    @(negedge clk); d0 = 8'h00; #1;
    total++; if (ov0 !== 1'b1 || od0 !== 8'hA4) begin bad++; $display("FAIL vec_byte0 got=%b/%h exp=1/a4", ov0, od0); end
    @(negedge clk); v0 = 0; #1;
    total++; if (ov0 !== 1'b1 || od0 !== 8'h68) begin bad++; $display("FAIL vec_byte1 got=%b/%h exp=1/68", ov0, od0); end
    @(negedge clk); #1;
    total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL vec_drain got=%b exp=0", ov0); end
  endtask

  task automatic test_backpressure();
    load0(16'h0001);
    v0 = 1; d0 = 8'hA5; r0 = 0;
    @(negedge clk); d0 = 8'h00; #1;
    total++; if (ov0 !== 1'b1 || od0 !== 8'hA4 || ir0 !== 1'b0) begin bad++; $display("FAIL bp_stall got=%b/%h/%b exp=1/a4/0", ov0, od0, ir0); end
    @(negedge clk); #1;
    total++; if (ov0 !== 1'b1 || od0 !== 8'hA4) begin bad++; $display("FAIL bp_hold got=%b/%h exp=1/a4", ov0, od0); end
    r0 = 1; #1;
    total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL bp_ready got=%b exp=1", ir0); end
    @(negedge clk); v0 = 0; #1;
    total++; if (ov0 !== 1'b1 || od0 !== 8'h68) begin bad++; $display("FAIL bp_next got=%b/%h exp=1/68", ov0, od0); end
    @(negedge clk); #1;
    total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", ov0); end
  endtask

  task automatic test_round_trip();
    logic [7:0] pt[256];
    logic [7:0] ct[256];
    logic [7:0] hold_d;
    logic       hold;
    int         sent, got;
    for (int i = 0; i < 256; i++) pt[i] = 8'($urandom);
    m_lfsr = 16'h1234;
    repeat (4) void'(m_next_byte());
    for (int i = 0; i < 256; i++) ct[i] = pt[i] ^ m_next_byte();
    load4(16'h1234);
    sent = 0; got = 0; hold = 0; hold_d = 0;
    for (int c = 0; c < 5000 && got < 256; c++) begin
      @(negedge clk);
      v4 = (sent < 256) && ($urandom_range(0, 3) != 0);
      d4 = v4 ? ct[sent] : 8'($urandom);
      r4 = ($urandom_range(0, 2) != 0);
      #1;
      if (hold) begin
        total++; if (ov4 !== 1'b1 || od4 !== hold_d) begin bad++; $display("FAIL rt_stable got=%b/%h exp=1/%h", ov4, od4, hold_d); end
      end
      if (ov4 && r4) begin
        total++; if (od4 !== pt[got]) begin bad++; $display("FAIL rt_byte%0d got=%h exp=%h", got, od4, pt[got]); end
        got++;
      end
      hold = ov4 && !r4; hold_d = od4;
      if (v4 && ir4) sent++;
    end
    total++; if (got != 256) begin bad++; $display("FAIL rt_count got=%0d exp=256", got); end
    @(negedge clk); v4 = 0; r4 = 0;
  endtask

  task automatic test_rekey();
    load0(16'h0001);
    v0 = 1; d0 = 8'h5A; r0 = 0;
    @(negedge clk); v0 = 0; #1;
    total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL rekey_pending got=%b exp=1", ov0); end
`ifdef SC_RX_BYTECNT_EN
    total++; if (bc0 !== 16'd1) begin bad++; $display("FAIL rekey_cnt1 got=%0d exp=1", bc0); end
`endif
    k0_load = 1; k0_key = 16'h0000; r0 = 1; #1;
    total++; if (ir0 !== 1'b0) begin bad++; $display("FAIL rekey_ready got=%b exp=0", ir0); end
    r0 = 0;
    @(negedge clk); k0_load = 0; #1;
    total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL rekey_drop got=%b exp=0", ov0); end
`ifdef SC_RX_BYTECNT_EN
    total++; if (bc0 !== 16'd0) begin bad++; $display("FAIL rekey_cnt0 got=%0d exp=0", bc0); end
`endif
    v0 = 1; d0 = 8'hA5; r0 = 1;
    @(negedge clk); d0 = 8'h00; #1;
    total++; if (od0 !== 8'hA4) begin bad++; $display("FAIL rekey_zero0 got=%h exp=a4", od0); end
    @(negedge clk); v0 = 0; #1;
    total++; if (od0 !== 8'h68) begin bad++; $display("FAIL rekey_zero1 got=%h exp=68", od0); end
`ifdef SC_RX_BYTECNT_EN
    total++; if (bc0 !== 16'd2) begin bad++; $display("FAIL rekey_cnt2 got=%0d exp=2", bc0); end
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_prime();
    test_vectors();
    test_backpressure();
    test_round_trip();
    test_rekey();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
